// File: rtl/note_recorder.sv
// Purpose : records a live key-scanner tone stream as {tone, beats} records for the music units.
// Latency : a write appears one cycle after its segment ends; KEY_TONE reaches acc_tone STABLE_CYC+1 cycles after it settles.
// Backpress: none; every WR_EN strobe is a fire-and-forget write that the RAM must accept.
module note_recorder #(
  parameter int ADDR_W     = 8,       // >= 2; last address holds the terminator
  parameter int BEAT_DIV   = 250000,  // >= 2 clock cycles per beat
  parameter int STABLE_CYC = 16       // >= 1 equal samples before a tone is accepted
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [6:0]        KEY_TONE,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [6:0]        TONE_DATA,
  output logic [7:0]        NOTE_DATA,
  output logic              RECORDING,
  output logic              FULL,
  output logic [3:0]        BCD1,
  output logic [3:0]        BCD0
);

  localparam int BC_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam int SC_W = $clog2(STABLE_CYC + 1);

  // Last record slot usable by RUN/FLUSH; the slot after it is the terminator.
  localparam logic [ADDR_W-1:0] LAST_REC = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(BEAT_DIV - 1);
  localparam logic [SC_W-1:0]   SC_FULL  = SC_W'(STABLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_TERM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;

  // Input conditioning
  logic              en_q;
  logic              en_rise;
  logic [6:0]        key_q;      // KEY_TONE registered once
  logic [6:0]        cand;       // previous key_q sample
  logic [SC_W-1:0]   run_len;    // consecutive equal key_q samples, saturating
  logic [SC_W-1:0]   run_next;
  logic [6:0]        acc_tone;   // accepted (debounced) tone

  // Segment tracking
  logic [6:0]        cur_tone;
  logic [7:0]        dur;
  logic [BC_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] count;      // records written, terminator excluded

  logic              tone_chg;
  logic              beat_wrap;

  assign en_rise   = EN & ~en_q;
  assign tone_chg  = (acc_tone != cur_tone);
  assign beat_wrap = (beat_cnt == BC_LAST);

  // Binary record count folded to two decimal digits.
  function automatic logic [7:0] to_bcd(input logic [ADDR_W-1:0] bin);
    int unsigned v;
    v = 32'(bin) % 100;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Length of the current run of identical samples, including this one.
  always_comb begin
    run_next = SC_W'(1);
    if (key_q == cand) begin
      run_next = (run_len == SC_FULL) ? run_len : run_len + 1'b1;
    end
  end

  // Edge detect on EN and debounce of the tone code.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_q     <= 1'b0;
      key_q    <= '0;
      cand     <= '0;
      run_len  <= '0;
      acc_tone <= '0;
    end else begin
      en_q    <= EN;
      key_q   <= KEY_TONE;
      cand    <= key_q;
      run_len <= run_next;
      if ((run_next == SC_FULL) && (key_q != acc_tone)) begin
        acc_tone <= key_q;
      end
    end
  end

  // Record-count display digits, one cycle behind the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BCD1 <= '0;
      BCD0 <= '0;
    end else begin
      {BCD1, BCD0} <= to_bcd(count);
    end
  end

  // Recorder FSM with registered write port and status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cur_tone  <= '0;
      dur       <= '0;
      beat_cnt  <= '0;
      addr      <= '0;
      count     <= '0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      TONE_DATA <= '0;
      NOTE_DATA <= '0;
      RECORDING <= 1'b0;
      FULL      <= 1'b0;
    end else begin
      WR_EN <= 1'b0;
      case (state)
        S_IDLE: begin
          addr  <= '0;
          count <= '0;
          FULL  <= 1'b0;
          if (en_rise) begin
            state     <= S_ARMED;
            RECORDING <= 1'b1;
          end
        end

        S_ARMED: begin
          // A stop before the first tone leaves only the terminator.
          if (en_rise) begin
            state     <= S_TERM;
            RECORDING <= 1'b0;
          end else if (acc_tone != 7'd0) begin
            // Leading rest is skipped; the first segment starts here.
            cur_tone <= acc_tone;
            dur      <= 8'd1;
            beat_cnt <= '0;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          if (en_rise) begin
            state     <= S_FLUSH;
            RECORDING <= 1'b0;
          end else if (tone_chg || (beat_wrap && (dur == 8'd255))) begin
            // Segment ends: a tone change wins over a coincident wrap, and a
            // saturated segment splits into a new record of the same tone.
            WR_EN     <= 1'b1;
            WR_ADDR   <= addr;
            TONE_DATA <= cur_tone;
            NOTE_DATA <= dur;
            addr      <= addr + 1'b1;
            count     <= count + 1'b1;
            cur_tone  <= acc_tone;
            dur       <= 8'd1;
            beat_cnt  <= '0;
            if (addr == LAST_REC) begin
              state     <= S_TERM;
              RECORDING <= 1'b0;
            end
          end else if (beat_wrap) begin
            beat_cnt <= '0;
            dur      <= dur + 8'd1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        S_FLUSH: begin
          // Close the open segment; tone changes no longer matter.
          WR_EN     <= 1'b1;
          WR_ADDR   <= addr;
          TONE_DATA <= cur_tone;
          NOTE_DATA <= dur;
          addr      <= addr + 1'b1;
          count     <= count + 1'b1;
          state     <= S_TERM;
        end

        S_TERM: begin
          WR_EN     <= 1'b1;
          WR_ADDR   <= addr;
          TONE_DATA <= 7'd0;
          NOTE_DATA <= 8'd0;
          FULL      <= 1'b1;
          state     <= S_DONE;
        end

        S_DONE: begin
          if (en_rise) begin
            state <= S_IDLE;
            addr  <= '0;
            count <= '0;
            FULL  <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          RECORDING <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with BEAT_DIV=4, STABLE_CYC=2, ADDR_W=3.
// Inputs change on the falling edge; writes are logged on the falling edge.
// Tone changes reach the FSM three rising edges after KEY_TONE changes.
module tb_note_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] key_tone;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [6:0] tone_data;
  logic [7:0] note_data;
  logic       recording;
  logic       full;
  logic [3:0] bcd1;
  logic [3:0] bcd0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wlog[$];

  note_recorder #(
    .ADDR_W    (3),
    .BEAT_DIV  (4),
    .STABLE_CYC(2)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .EN       (en),
    .KEY_TONE (key_tone),
    .WR_EN    (wr_en),
    .WR_ADDR  (wr_addr),
    .TONE_DATA(tone_data),
    .NOTE_DATA(note_data),
    .RECORDING(recording),
    .FULL     (full),
    .BCD1     (bcd1),
    .BCD0     (bcd0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [2:0] a, input logic [6:0] t, input logic [7:0] n);
    return {14'd0, a, t, n};
  endfunction

  always @(negedge clk) begin
    if (wr_en) wlog.push_back(enc(wr_addr, tone_data, note_data));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_en();
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  // DONE -> IDLE -> ARMED
  task automatic rearm();
    pulse_en();
    tick(1);
    pulse_en();
    tick(1);
  endtask

  function automatic logic [31:0] all_outs();
    return {3'd0, wr_en, wr_addr, tone_data, note_data, recording, full, bcd1, bcd0};
  endfunction

  initial begin
    rst = 1'b1;
    en = 1'b0;
    key_tone = 7'd0;
    tick(2);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    tick(2);

    // ---- reset in the middle of RUN ----
    pulse_en();
    key_tone = 7'd50;
    tick(8);
    key_tone = 7'd51;
    tick(8);
    check("prerst_tone", {25'd0, tone_data}, 32'd50);
    check("prerst_note", {24'd0, note_data}, 32'd2);
    check("prerst_bcd", {24'd0, bcd1, bcd0}, 32'h01);
    check("prerst_recording", {31'd0, recording}, 32'd1);
    #2 rst = 1'b1;
    #1 check("midrst_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    key_tone = 7'd0;
    tick(4);

    // ---- basic: 22 for 10 cycles, rest for 8, stop ----
    wlog.delete();
    pulse_en();
    check("basic_armed", {31'd0, recording}, 32'd1);
    key_tone = 7'd22;
    tick(10);
    key_tone = 7'd0;
    tick(8);
    pulse_en();
    tick(6);
    check("basic_nrec", wlog.size(), 32'd3);
    check("basic_rec0", wlog[0], enc(3'd0, 7'd22, 8'd3));
    check("basic_rec1", wlog[1], enc(3'd1, 7'd0, 8'd2));
    check("basic_term", wlog[2], enc(3'd2, 7'd0, 8'd0));
    check("basic_bcd", {24'd0, bcd1, bcd0}, 32'h02);
    check("basic_full", {31'd0, full}, 32'd1);
    check("basic_stopped", {31'd0, recording}, 32'd0);

    // ---- glitch: one-cycle blip to 31 inside tone 30 ----
    wlog.delete();
    pulse_en();
    tick(1);
    check("idle_full_clr", {31'd0, full}, 32'd0);
    check("idle_bcd_clr", {24'd0, bcd1, bcd0}, 32'h00);
    pulse_en();
    key_tone = 7'd30;
    tick(6);
    key_tone = 7'd31;
    tick(1);
    key_tone = 7'd30;
    tick(5);
    pulse_en();
    tick(6);
    check("glitch_nrec", wlog.size(), 32'd2);
    check("glitch_rec0", wlog[0], enc(3'd0, 7'd30, 8'd3));
    check("glitch_term", wlog[1], enc(3'd1, 7'd0, 8'd0));
    key_tone = 7'd0;
    tick(4);

    // ---- saturation: tone 40 for 255 + 21 beats ----
    wlog.delete();
    rearm();
    key_tone = 7'd40;
    tick(1105);
    pulse_en();
    tick(6);
    check("sat_nrec", wlog.size(), 32'd3);
    check("sat_rec0", wlog[0], enc(3'd0, 7'd40, 8'd255));
    check("sat_rec1", wlog[1], enc(3'd1, 7'd40, 8'd21));
    check("sat_term", wlog[2], enc(3'd2, 7'd0, 8'd0));
    check("sat_bcd", {24'd0, bcd1, bcd0}, 32'h02);
    key_tone = 7'd0;
    tick(4);

    // ---- full: alternating 25/26, 4 cycles each ----
    wlog.delete();
    rearm();
    for (int i = 0; i < 8; i++) begin
      key_tone = (i % 2 == 0) ? 7'd25 : 7'd26;
      tick(4);
    end
    key_tone = 7'd27;
    tick(4);
    key_tone = 7'd25;
    tick(4);
    key_tone = 7'd0;
    tick(6);
    check("full_nrec", wlog.size(), 32'd8);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("full_rec%0d", i), wlog[i],
            enc(3'(i), (i % 2 == 0) ? 7'd25 : 7'd26, 8'd1));
    end
    check("full_term", wlog[7], enc(3'd7, 7'd0, 8'd0));
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_bcd", {24'd0, bcd1, bcd0}, 32'h07);
    check("full_addr_hold", {29'd0, wr_addr}, 32'd7);
    check("full_stopped", {31'd0, recording}, 32'd0);

    // ---- immediate stop while ARMED ----
    wlog.delete();
    rearm();
    check("imm_armed", {31'd0, recording}, 32'd1);
    pulse_en();
    tick(4);
    check("imm_nrec", wlog.size(), 32'd1);
    check("imm_term", wlog[0], enc(3'd0, 7'd0, 8'd0));
    check("imm_full", {31'd0, full}, 32'd1);
    check("imm_bcd", {24'd0, bcd1, bcd0}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
